// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    KILL,
    HOLD
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  // Wraps modulo 2^32 with no carry out.
  function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory req/ack handshake between the fetch stage and memory.
interface fetch_if;

  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemAck,
    input  IMemData
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemAck,
    output IMemData
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc4} holding register; Clear wins over Load.
module fetch_skid_buffer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Load,
  input  logic        Clear,
  input  logic [31:0] InstrIn,
  input  logic [31:0] Pc4In,
  output logic [31:0] Instr,
  output logic [31:0] Pc4,
  output logic        Valid
);

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      Instr <= '0;
      Pc4   <= '0;
      Valid <= 1'b0;
    end else if (Load) begin
      Instr <= InstrIn;
      Pc4   <= Pc4In;
      Valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, memory handshake FSM, skid buffer and IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        RedirectE,
  input  logic [31:0] RedirectPCE,
  fetch_if.master     IMem,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  import fetch_pkg::*;

  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  killAddr;
  if_id_t       ifId;

  logic         skidLoad;
  logic         skidClear;
  logic [31:0]  skidInstr;
  logic [31:0]  skidPc4;
  logic         skidValid;

  // The stale request's address must stay on the bus in KILL while pc already holds the target.
  assign IMem.IMemReq  = (state == RUN) || (state == KILL);
  assign IMem.IMemAddr = (state == KILL) ? killAddr : pc;

  assign InstrD   = ifId.instr;
  assign PCPlus4D = ifId.pc4;
  assign ValidD   = ifId.valid;

  always_comb begin
    skidLoad  = 1'b0;
    skidClear = 1'b0;
    if (!Reset) begin
      if (RedirectE) begin
        skidClear = 1'b1;
      end else if (state == RUN && Stall && IMem.IMemAck) begin
        skidLoad = 1'b1;
      end else if (state == HOLD && !Stall) begin
        skidClear = 1'b1;
      end
    end
  end

  fetch_skid_buffer u_skid (
    .Clock   (Clock),
    .Reset   (Reset),
    .Load    (skidLoad),
    .Clear   (skidClear),
    .InstrIn (IMem.IMemData),
    .Pc4In   (pcPlus4(pc)),
    .Instr   (skidInstr),
    .Pc4     (skidPc4),
    .Valid   (skidValid)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      killAddr <= RESET_PC;
      ifId     <= BUBBLE;
    end else if (RedirectE) begin
      ifId <= BUBBLE;
      pc   <= wordAlign(RedirectPCE);
      if ((state == RUN || state == KILL) && !IMem.IMemAck) begin
        state <= KILL;
        if (state == RUN) begin
          killAddr <= pc;
        end
      end else begin
        state <= RUN;
      end
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
        end
        RUN: begin
          if (Stall) begin
            if (IMem.IMemAck) begin
              pc    <= pcPlus4(pc);
              state <= HOLD;
            end
          end else if (IMem.IMemAck) begin
            ifId <= '{instr: IMem.IMemData, pc4: pcPlus4(pc), valid: 1'b1};
            pc   <= pcPlus4(pc);
          end else begin
            ifId <= BUBBLE;
          end
        end
        KILL: begin
          if (!Stall) begin
            ifId <= BUBBLE;
          end
          if (IMem.IMemAck) begin
            state <= RUN;
          end
        end
        HOLD: begin
          if (!Stall) begin
            ifId  <= '{instr: skidInstr, pc4: skidPc4, valid: skidValid};
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
